// File: rtl/regfile_wr_arbiter_if.sv
// rtl/regfile_wr_arbiter_if.sv - writeback request / register-file write-port bundle
interface regfile_wr_arbiter_if #(
  parameter int W    = 32,
  parameter int AW   = 5,
  parameter int NREQ = 2
);
  // writeback requesters
  logic [NREQ-1:0]    req_valid_i;
  logic [NREQ*AW-1:0] req_addr_i;
  logic [NREQ*W-1:0]  req_data_i;
  logic [NREQ-1:0]    req_ready_o;
  // clear sweep control
  logic               clr_i;
  logic               busy_o;
  logic               clr_done_o;
  // register-file write port
  logic               wr_en_o;
  logic [AW-1:0]      wr_addr_o;
  logic [W-1:0]       wr_data_o;

  // requester / observer side
  modport master (
    output req_valid_i, req_addr_i, req_data_i, clr_i,
    input  req_ready_o, busy_o, clr_done_o, wr_en_o, wr_addr_o, wr_data_o
  );

  // arbiter side
  modport slave (
    input  req_valid_i, req_addr_i, req_data_i, clr_i,
    output req_ready_o, busy_o, clr_done_o, wr_en_o, wr_addr_o, wr_data_o
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - round-robin writeback arbiter with register-file clear sweep
module regfile_wr_arbiter #(
  parameter int W    = 32,
  parameter int AW   = 5,
  parameter int NREQ = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  regfile_wr_arbiter_if.slave bus
);

  localparam int NREG = 2 ** AW;
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW-1:0] CNT_LAST = AW'(NREG - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [W-1:0]    wr_data_q, wr_data_d;
  logic            clr_done_q, clr_done_d;

  logic            arb_en;
  logic            grant_found;
  logic [PW-1:0]   grant_idx;
  int              scan_idx;
  logic [NREQ-1:0] req_ready;
  logic            handshake;
  logic [AW-1:0]   win_addr;
  logic [W-1:0]    win_data;
  logic [PW-1:0]   ptr_next;

  // Grants are only offered while idle with no clear request and out of reset.
  assign arb_en = (state_q == S_IDLE) && !bus.clr_i && !rst_i;

  // Round-robin scan: first valid requester starting at ptr, wrapping mod NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = int'(ptr_q) + k;
      if (scan_idx >= NREQ) begin
        scan_idx = scan_idx - NREQ;
      end
      if (!grant_found && bus.req_valid_i[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = PW'(scan_idx);
      end
    end
  end

  // One-hot ready to the winner; the winner is valid by construction, so a grant is a handshake.
  always_comb begin
    req_ready = '0;
    if (arb_en && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign handshake = arb_en && grant_found;
  assign win_addr  = bus.req_addr_i[int'(grant_idx)*AW +: AW];
  assign win_data  = bus.req_data_i[int'(grant_idx)*W +: W];
  assign ptr_next  = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;

  // Next-state and write-port logic: clear sweep owns the port, otherwise the winner does.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    clr_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.clr_i) begin
          state_d = S_CLEAR;
          cnt_d   = AW'(1);
        end else if (handshake) begin
          ptr_d = ptr_next;
          // register 0 is hardwired zero: accept the request but drop the write
          if (win_addr != '0) begin
            wr_en_d   = 1'b1;
            wr_addr_d = win_addr;
            wr_data_d = win_data;
          end
        end
      end
      S_CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d    = S_IDLE;
          clr_done_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered write port; reset also aborts any sweep in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      clr_done_q <= clr_done_d;
    end
  end

  assign bus.req_ready_o = req_ready;
  assign bus.busy_o      = (state_q == S_CLEAR);
  assign bus.clr_done_o  = clr_done_q;
  assign bus.wr_en_o     = wr_en_q;
  assign bus.wr_addr_o   = wr_addr_q;
  assign bus.wr_data_o   = wr_data_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - scoreboard bench for regfile_wr_arbiter
module tb_regfile_wr_arbiter;
  localparam int W    = 32;
  localparam int AW   = 5;
  localparam int NREQ = 2;
  localparam int NREG = 2 ** AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wr_arbiter_if #(.W(W), .AW(AW), .NREQ(NREQ)) bus ();

  regfile_wr_arbiter #(.W(W), .AW(AW), .NREQ(NREQ)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } wr_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } req_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  wr_t  exp_q[$];
  req_t req_q[NREQ][$];

  // reference model state
  int   m_ptr = 0;
  bit   clr_active = 0;
  int   clr_t = 0;
  int   done_due = -1;
  bit   rst_prev = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: checks handshake-side outputs and books expected port writes.
  always @(negedge clk) begin : model
    logic [NREQ-1:0] exp_ready;
    bit              in_clear;
    int              g;
    int              idx;
    in_clear  = clr_active && (cyc <= clr_t + NREG - 1);
    exp_ready = '0;
    g         = -1;
    if (!rst && !in_clear && !bus.clr_i) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (g < 0 && bus.req_valid_i[idx]) g = idx;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", 64'(bus.req_ready_o), 64'(exp_ready));
    check("busy", 64'(bus.busy_o), 64'(in_clear));
    check("clr_done", 64'(bus.clr_done_o), 64'(done_due == cyc));
    if (rst_prev) begin
      check("rst_wr_addr", 64'(bus.wr_addr_o), 64'(0));
      check("rst_wr_data", 64'(bus.wr_data_o), 64'(0));
    end
    if (rst) begin
      m_ptr      = 0;
      clr_active = 0;
      done_due   = -1;
      while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
    end else if (in_clear) begin
      if (cyc >= clr_t + NREG - 1) clr_active = 0;
    end else if (bus.clr_i) begin
      clr_active = 1;
      clr_t      = cyc;
      done_due   = cyc + NREG;
      for (int a = 1; a < NREG; a++) exp_q.push_back('{cyc + 1 + a, AW'(a), '0});
    end else if (g >= 0) begin
      if (bus.req_addr_i[g*AW +: AW] != '0)
        exp_q.push_back('{cyc + 1, bus.req_addr_i[g*AW +: AW], bus.req_data_i[g*W +: W]});
      m_ptr = (g + 1) % NREQ;
    end
    rst_prev = rst;
  end

  // Monitor: compares the write port against the scoreboard entry due this cycle.
  always @(negedge clk) begin : monitor
    bit  due;
    wr_t e;
    due = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    check("wr_en", 64'(bus.wr_en_o), 64'(due));
    if (due) begin
      e = exp_q.pop_front();
      if (bus.wr_en_o) begin
        check("wr_addr", 64'(bus.wr_addr_o), 64'(e.addr));
        check("wr_data", 64'(bus.wr_data_o), 64'(e.data));
      end
    end
  end

  // Requester driver: holds each queued write until its handshake.
  initial begin : driver
    logic [NREQ-1:0]    v;
    logic [NREQ*AW-1:0] a;
    logic [NREQ*W-1:0]  d;
    bus.req_valid_i = '0;
    bus.req_addr_i  = '0;
    bus.req_data_i  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++)
        if (bus.req_valid_i[i] && bus.req_ready_o[i] && req_q[i].size() > 0)
          void'(req_q[i].pop_front());
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (req_q[i].size() > 0) begin
          v[i]          = 1'b1;
          a[i*AW +: AW] = req_q[i][0].addr;
          d[i*W +: W]   = req_q[i][0].data;
        end else begin
          v[i]          = 1'b0;
          a[i*AW +: AW] = '0;
          d[i*W +: W]   = '0;
        end
      end
      bus.req_valid_i = v;
      bus.req_addr_i  = a;
      bus.req_data_i  = d;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(int i, int addr, logic [W-1:0] data);
    req_q[i].push_back('{AW'(addr), data});
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((req_q[0].size() > 0 || req_q[1].size() > 0) && n < 300) begin
      step();
      n++;
    end
    check("drain_timeout", 64'(req_q[0].size() + req_q[1].size()), 64'(0));
    repeat (2) step();
  endtask

  // Stimulus: directed scenarios followed by randomized traffic with clears and resets.
  initial begin : stimulus
    rst = 1'b1;
    bus.clr_i = 1'b0;
    push(0, 7, 32'h0000_0007);
    push(1, 8, 32'h0000_0008);
    repeat (2) step();
    rst = 1'b0;
    wait_idle();

    push(0, 5, 32'hDEAD_BEEF);
    wait_idle();

    for (int k = 0; k < 4; k++) begin
      push(0, 3, $urandom);
      push(1, 4, $urandom);
    end
    wait_idle();

    push(0, 9, $urandom);
    wait_idle();
    push(1, 0, $urandom);
    wait_idle();
    push(0, 10, 32'hA0A0_0010);
    push(1, 11, 32'hB1B1_0011);
    wait_idle();

    push(0, 12, 32'hC0DE_0012);
    step();
    bus.clr_i = 1'b1;
    step();
    bus.clr_i = 1'b0;
    wait_idle();

    bus.clr_i = 1'b1;
    step();
    bus.clr_i = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    push(0, 13, 32'h1313_1313);
    wait_idle();

    for (int it = 0; it < 1500; it++) begin
      for (int i = 0; i < NREQ; i++)
        if (req_q[i].size() < 3 && $urandom_range(0, 2) == 0)
          push(i, int'($urandom_range(0, NREG - 1)), $urandom);
      bus.clr_i = ($urandom_range(0, 59) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      step();
    end
    bus.clr_i = 1'b0;
    rst       = 1'b0;
    wait_idle();
    repeat (NREG + 4) step();
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
